// File: rtl/morse_decoder.sv
// Morse decoder: samples a mark/space line on sym_tick and decodes letters S..Z.
// Define MORSE_DEC_ERRCNT_EN to add the saturating err_count output.
module morse_decoder #(
    parameter int GAP_LEN   = 3,
    parameter int MAX_ELEMS = 5
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sym_tick,
    input  logic       sym_in,
    output logic [2:0] letter,
    output logic       letter_valid,
    output logic       letter_error,
`ifdef MORSE_DEC_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    localparam logic [2:0] GAP_END  = 3'(GAP_LEN);
    localparam logic [2:0] ELEM_MAX = 3'(MAX_ELEMS);

    state_t     state, state_nx;
    logic [2:0] run, run_nx;
    logic [2:0] gap, gap_nx;
    logic [2:0] count, count_nx;
    logic [6:0] elems, elems_nx;
    logic       bad, bad_nx;
    logic [2:0] letter_nx;
    logic       valid_nx;
    logic       error_nx;

    logic [2:0] code;
    logic       known;
    logic       is_dot;
    logic       is_dash;
    logic [2:0] gap_inc;

    assign is_dot  = (run == 3'd1);
    assign is_dash = (run == 3'd3);
    assign gap_inc = gap + 3'd1;
    assign busy    = (state != IDLE);

    // Element bit i is element i (first element in bit 0); 1 = dash.
    always_comb begin
        code  = 3'd0;
        known = 1'b1;
        case ({count, elems})
            {3'd3, 7'b0000000}: code = 3'd0;
            {3'd1, 7'b0000001}: code = 3'd1;
            {3'd3, 7'b0000100}: code = 3'd2;
            {3'd4, 7'b0001000}: code = 3'd3;
            {3'd3, 7'b0000110}: code = 3'd4;
            {3'd4, 7'b0001001}: code = 3'd5;
            {3'd4, 7'b0001101}: code = 3'd6;
            {3'd4, 7'b0000011}: code = 3'd7;
            default:            known = 1'b0;
        endcase
    end

    always_comb begin
        state_nx  = state;
        run_nx    = run;
        gap_nx    = gap;
        count_nx  = count;
        elems_nx  = elems;
        bad_nx    = bad;
        letter_nx = letter;
        valid_nx  = 1'b0;
        error_nx  = 1'b0;
        if (sym_tick) begin
            unique case (state)
                IDLE: begin
                    if (sym_in) begin
                        state_nx = MARK;
                        run_nx   = 3'd1;
                        gap_nx   = 3'd0;
                        count_nx = 3'd0;
                        elems_nx = 7'd0;
                        bad_nx   = 1'b0;
                    end
                end
                MARK: begin
                    if (sym_in) begin
                        if (run != 3'd7) begin
                            run_nx = run + 3'd1;
                        end
                    end else begin
                        state_nx = SPACE;
                        run_nx   = 3'd0;
                        gap_nx   = 3'd1;
                        if (!(is_dot || is_dash) || count >= ELEM_MAX) begin
                            bad_nx = 1'b1;
                        end else begin
                            elems_nx = elems | (7'(is_dash) << count);
                            count_nx = count + 3'd1;
                        end
                    end
                end
                SPACE: begin
                    if (sym_in) begin
                        state_nx = MARK;
                        run_nx   = 3'd1;
                        gap_nx   = 3'd0;
                        if (gap != 3'd1) begin
                            bad_nx = 1'b1;
                        end
                    end else if (gap_inc == GAP_END) begin
                        state_nx = IDLE;
                        gap_nx   = 3'd0;
                        if (known && !bad) begin
                            valid_nx  = 1'b1;
                            letter_nx = code;
                        end else begin
                            error_nx = 1'b1;
                        end
                    end else begin
                        gap_nx = gap_inc;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            run          <= 3'd0;
            gap          <= 3'd0;
            count        <= 3'd0;
            elems        <= 7'd0;
            bad          <= 1'b0;
            letter       <= 3'd0;
            letter_valid <= 1'b0;
            letter_error <= 1'b0;
        end else begin
            state        <= state_nx;
            run          <= run_nx;
            gap          <= gap_nx;
            count        <= count_nx;
            elems        <= elems_nx;
            bad          <= bad_nx;
            letter       <= letter_nx;
            letter_valid <= valid_nx;
            letter_error <= error_nx;
        end
    end

`ifdef MORSE_DEC_ERRCNT_EN
    // Counts in step with the error pulse so both are visible together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= 8'd0;
        end else if (error_nx && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_morse_decoder.sv
// Table-driven bench for morse_decoder with a pulse scoreboard.
// Define MORSE_DEC_ERRCNT_EN to also check err_count.
module tb_morse_decoder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       sym_tick = 1'b0;
    logic       sym_in = 1'b0;
    logic [2:0] letter;
    logic       letter_valid;
    logic       letter_error;
    logic       busy;
`ifdef MORSE_DEC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int total = 0;
    int bad = 0;
    int n_samp;
    int err_model = 0;
    logic [2:0] cur_letter = 3'd0;

    typedef struct {
        bit         err;
        logic [2:0] ltr;
        int         tick;
    } exp_t;

    typedef struct {
        string      bits;
        bit         v;
        bit         e;
        logic [2:0] ltr;
        int         end_pos;
    } vec_t;

    exp_t q[$];
    exp_t m;
    vec_t tbl[15];

    morse_decoder #(.GAP_LEN(3), .MAX_ELEMS(5)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .sym_tick(sym_tick),
        .sym_in(sym_in),
        .letter(letter),
        .letter_valid(letter_valid),
        .letter_error(letter_error),
`ifdef MORSE_DEC_ERRCNT_EN
        .err_count(err_count),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) n_samp <= 0;
        else if (sym_tick) n_samp <= n_samp + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && (letter_valid || letter_error)) begin
            chk("exclusive", int'(letter_valid && letter_error), 0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                m = q.pop_front();
                chk("kind", int'(letter_error), int'(m.err));
                chk("letter", int'(letter), int'(m.ltr));
                chk("latency", n_samp, m.tick);
            end
        end
    end

    task automatic tick(input logic b, input int idle);
        sym_in   = b;
        sym_tick = 1'b1;
        @(negedge clock);
        sym_tick = 1'b0;
        sym_in   = 1'b0;
        repeat (idle) @(negedge clock);
    endtask

    task automatic run_stream(input string s, input bit v, input bit e,
                              input logic [2:0] l, input int endp,
                              input int idle);
        exp_t x;
        if (v || e) begin
            x.err  = e;
            x.ltr  = v ? l : cur_letter;
            x.tick = n_samp + endp;
            q.push_back(x);
            if (v) cur_letter = l;
            if (e && err_model < 255) err_model++;
        end
        for (int i = 0; i < s.len(); i++) begin
            tick(s[i] == 8'h31, idle);
        end
        repeat (4) tick(1'b0, 0);
        chk("busy_after", int'(busy), 0);
        chk("pending", q.size(), 0);
        q.delete();
        chk("letter_hold", int'(letter), int'(cur_letter));
`ifdef MORSE_DEC_ERRCNT_EN
        chk("err_count", int'(err_count), err_model);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{"1010100000000000", 1'b1, 1'b0, 3'd0, 8};
        tbl[1]  = '{"1110111010100000", 1'b1, 1'b0, 3'd7, 14};
        tbl[2]  = '{"1110101110111000", 1'b1, 1'b0, 3'd6, 16};
        tbl[3]  = '{"11000",            1'b0, 1'b1, 3'd0, 5};
        tbl[4]  = '{"10101010100000",   1'b0, 1'b1, 3'd0, 12};
        tbl[5]  = '{"101010101010000",  1'b0, 1'b1, 3'd0, 14};
        tbl[6]  = '{"1110000",          1'b1, 1'b0, 3'd1, 6};
        tbl[7]  = '{"1010111000",       1'b1, 1'b0, 3'd2, 10};
        tbl[8]  = '{"10101011100000",   1'b1, 1'b0, 3'd3, 12};
        tbl[9]  = '{"10111011100000",   1'b1, 1'b0, 3'd4, 12};
        tbl[10] = '{"1110101011100000", 1'b1, 1'b0, 3'd5, 14};
        tbl[11] = '{"1001000",          1'b0, 1'b1, 3'd0, 7};
        tbl[12] = '{"111111111000",     1'b0, 1'b1, 3'd0, 12};
        tbl[13] = '{"0000000000",       1'b0, 1'b0, 3'd0, 0};
        tbl[14] = '{"1010100000",       1'b1, 1'b0, 3'd0, 8};

        repeat (2) @(negedge clock);
        chk("rst_letter", int'(letter), 0);
        chk("rst_valid", int'(letter_valid), 0);
        chk("rst_error", int'(letter_error), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef MORSE_DEC_ERRCNT_EN
        chk("rst_errcnt", int'(err_count), 0);
`endif
        reset_n = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 15; k++) begin
            run_stream(tbl[k].bits, tbl[k].v, tbl[k].e, tbl[k].ltr,
                       tbl[k].end_pos, 0);
        end

        // Strobe idles 10 cycles between samples.
        run_stream("10101000", 1'b1, 1'b0, 3'd0, 8, 10);
        run_stream("1110000", 1'b1, 1'b0, 3'd1, 6, 3);

        // Reset in the middle of a letter discards it.
        tick(1'b1, 0);
        tick(1'b1, 0);
        tick(1'b1, 0);
        tick(1'b0, 0);
        tick(1'b1, 0);
        chk("busy_mid", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_letter", int'(letter), 0);
        cur_letter = 3'd0;
        err_model  = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_stream("1110000", 1'b1, 1'b0, 3'd1, 6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
